// File: rtl/decoded_msg_reader.sv
// Latches the winning key, reads decoded bytes from Decoded_RAM, streams key(3B, MSB first) + message bytes.
// Latency: first key byte valid 1 cycle after start; 4 cycles per message byte; done 3+4*MSG_LEN cycles after KEY entry.
// Backpressure: registered tx_valid/tx_data held stable while tx_ready is low; RAM is not re-read during a stall.
module decoded_msg_reader #(
   parameter int MSG_LEN = 32,
   parameter int ADDR_W  = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [23:0]       secret_key,
   output logic [ADDR_W-1:0] ram_address,
   input  logic [7:0]        ram_q,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEY,
      S_ADDR,
      S_WAIT,
      S_CAPT,
      S_SEND,
      S_DONE
   } state_t;

   // msg_idx carries one extra bit so MSG_LEN = 2^ADDR_W ends without wrapping
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MSG_LEN - 1);

   state_t              state_q, state_d;
   logic [23:0]         key_q, key_d;
   logic [1:0]          key_idx_q, key_idx_d;
   logic [ADDR_W:0]     msg_idx_q, msg_idx_d;
   logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                xfer;

   assign xfer        = tx_valid_q & tx_ready;
   assign ram_address = ram_address_q;
   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;

   // Next-state and registered-output logic for the frame sequencer
   always_comb begin
      state_d       = state_q;
      key_d         = key_q;
      key_idx_d     = key_idx_q;
      msg_idx_d     = msg_idx_q;
      ram_address_d = ram_address_q;
      tx_data_d     = tx_data_q;
      tx_valid_d    = tx_valid_q;
      busy_d        = busy_q;
      done_d        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               key_d      = secret_key;
               key_idx_d  = 2'd0;
               busy_d     = 1'b1;
               tx_data_d  = secret_key[23:16];
               tx_valid_d = 1'b1;
               state_d    = S_KEY;
            end
         end
         S_KEY: begin
            if (xfer) begin
               if (key_idx_q == 2'd2) begin
                  tx_valid_d = 1'b0;
                  msg_idx_d  = '0;
                  state_d    = S_ADDR;
               end else begin
                  key_idx_d = key_idx_q + 2'd1;
                  // Present the following key byte on the next cycle
                  tx_data_d = (key_idx_q == 2'd0) ? key_q[15:8] : key_q[7:0];
               end
            end
         end
         S_ADDR: begin
            ram_address_d = msg_idx_q[ADDR_W-1:0];
            state_d       = S_WAIT;
         end
         S_WAIT: begin
            // RAM registers the address this cycle; data is usable next cycle
            state_d = S_CAPT;
         end
         S_CAPT: begin
            tx_data_d  = ram_q;
            tx_valid_d = 1'b1;
            state_d    = S_SEND;
         end
         S_SEND: begin
            if (xfer) begin
               tx_valid_d = 1'b0;
               if (msg_idx_q == LAST_IDX) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  msg_idx_d = msg_idx_q + 1'b1;
                  state_d   = S_ADDR;
               end
            end
         end
         S_DONE: begin
            // busy stays high through this cycle so a start here is ignored
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in progress
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         key_q         <= '0;
         key_idx_q     <= '0;
         msg_idx_q     <= '0;
         ram_address_q <= '0;
         tx_data_q     <= '0;
         tx_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         key_q         <= key_d;
         key_idx_q     <= key_idx_d;
         msg_idx_q     <= msg_idx_d;
         ram_address_q <= ram_address_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

endmodule

// File: tb/tb_decoded_msg_reader.sv
module tb_decoded_msg_reader;

   localparam int MSG_LEN = 32;
   localparam int ADDR_W  = 5;
   localparam int FRAME   = 3 + MSG_LEN;

   logic              clk;
   logic              reset_n;
   logic              start;
   logic [23:0]       secret_key;
   logic [ADDR_W-1:0] ram_address;
   logic [7:0]        ram_q;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              busy;
   logic              done;

   int errs;
   int checks;

   logic [7:0] mem [32];
   logic       lat_mode;
   logic [7:0] rx_q[$];
   logic [ADDR_W-1:0] addr_q[$];
   int         xcnt;
   int         done_cnt;
   logic       a1, a2;

   decoded_msg_reader #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .secret_key  (secret_key),
      .ram_address (ram_address),
      .ram_q       (ram_q),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model (1-cycle read latency) and stream monitor
   always @(posedge clk) begin
      if (start && !busy) begin
         rx_q.delete();
         addr_q.delete();
         xcnt     <= 0;
         done_cnt <= 0;
      end
      if (tx_valid && tx_ready) begin
         rx_q.push_back(tx_data);
         if (xcnt >= 3) addr_q.push_back(ram_address);
         xcnt <= xcnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      // a1: this edge is an address-update edge; a2: address was updated on the previous edge
      a1 <= tx_valid && tx_ready && (xcnt >= 2) && (xcnt <= MSG_LEN + 1);
      a2 <= a1;
      if (lat_mode) ram_q <= a2 ? mem[ram_address] : 8'hxx;
      else          ram_q <= mem[ram_address];
   end

   function automatic logic [7:0] exp_byte(input logic [23:0] k, input int i);
      if (i == 0) return k[23:16];
      if (i == 1) return k[15:8];
      if (i == 2) return k[7:0];
      return 8'h41 + 8'(i - 3);
   endfunction

   // Waits (bounded) for done; cyc = negedges after the start edge, -1 on timeout
   task automatic wait_done(input int lim, output int cyc);
      cyc = -1;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin errs++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
      checks++; if (ram_address !== 5'd0) begin errs++; $display("FAIL reset_ram_address got=%0d exp=0", ram_address); end
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", done); end
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errs++; $display("FAIL post_reset_idle busy=%b valid=%b exp=0,0", busy, tx_valid); end
   endtask

   task automatic test_basic();
      int cyc;
      tx_ready = 1'b1;
      secret_key = 24'h0249B4;
      start = 1'b1;
      wait_done(400, cyc);
      checks++; if (cyc != 131) begin errs++; $display("FAIL basic_done_latency got=%0d exp=131", cyc); end
      checks++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy_in_done got=%b exp=1", busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL basic_after_done busy=%b done=%b exp=0,0", busy, done); end
      checks++; if (done_cnt != 1) begin errs++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
      checks++; if (rx_q.size() != FRAME) begin errs++; $display("FAIL basic_len got=%0d exp=%0d", rx_q.size(), FRAME); end
      for (int i = 0; i < rx_q.size() && i < FRAME; i++) begin
         checks++;
         if (rx_q[i] !== exp_byte(24'h0249B4, i)) begin errs++; $display("FAIL basic_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_byte(24'h0249B4, i)); end
      end
      checks++; if (addr_q.size() != MSG_LEN) begin errs++; $display("FAIL basic_addr_len got=%0d exp=%0d", addr_q.size(), MSG_LEN); end
      for (int i = 0; i < addr_q.size() && i < MSG_LEN; i++) begin
         checks++;
         if (addr_q[i] !== 5'(i)) begin errs++; $display("FAIL basic_addr[%0d] got=%0d exp=%0d", i, addr_q[i], i); end
      end
      checks++; if (ram_address !== 5'd31) begin errs++; $display("FAIL basic_addr_hold got=%0d exp=31", ram_address); end
      repeat (3) @(negedge clk);
      checks++; if (done_cnt != 1 || busy !== 1'b0) begin errs++; $display("FAIL basic_quiet done_cnt=%0d busy=%b exp=1,0", done_cnt, busy); end
   endtask

   task automatic test_backpressure();
      logic [15:0] lfsr;
      logic        prev_v, prev_r, did1, did2, seen;
      logic [7:0]  prev_d;
      int          hold;
      lfsr = 16'hACE1; hold = 0; did1 = 0; did2 = 0; seen = 0;
      secret_key = 24'h0249B4;
      tx_ready = 1'b1;
      start = 1'b1;
      prev_v = 1'b0; prev_r = 1'b1; prev_d = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (prev_v && !prev_r) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== prev_d) begin
               errs++; $display("FAIL bp_stall_hold cyc=%0d valid=%b data=%h exp=1,%h", c, tx_valid, tx_data, prev_d);
            end
         end
         if (done) begin seen = 1; break; end
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (hold > 0) begin
            hold--; tx_ready = 1'b0;
         end else if (!did1 && xcnt == 1) begin
            did1 = 1; hold = 9; tx_ready = 1'b0;
         end else if (!did2 && xcnt == 13) begin
            did2 = 1; hold = 9; tx_ready = 1'b0;
         end else begin
            tx_ready = lfsr[0] | lfsr[3];
         end
         prev_v = tx_valid; prev_d = tx_data; prev_r = tx_ready;
      end
      checks++; if (!seen) begin errs++; $display("FAIL bp_done_timeout got=none exp=done"); end
      tx_ready = 1'b1;
      @(negedge clk);
      checks++; if (done_cnt != 1) begin errs++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
      checks++; if (rx_q.size() != FRAME) begin errs++; $display("FAIL bp_len got=%0d exp=%0d", rx_q.size(), FRAME); end
      for (int i = 0; i < rx_q.size() && i < FRAME; i++) begin
         checks++;
         if (rx_q[i] !== exp_byte(24'h0249B4, i)) begin errs++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_byte(24'h0249B4, i)); end
      end
   endtask

   task automatic test_ignore_start();
      logic pulsed, seen, stray;
      pulsed = 0; seen = 0; stray = 0;
      tx_ready = 1'b1;
      secret_key = 24'h0249B4;
      start = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            seen = 1;
            secret_key = 24'h000001;
            start = 1'b1;
            break;
         end
         if (!pulsed && xcnt == 1) begin
            pulsed = 1;
            secret_key = 24'h000001;
            start = 1'b1;
         end
      end
      checks++; if (!seen) begin errs++; $display("FAIL ign_done_timeout got=none exp=done"); end
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (busy !== 1'b0 || tx_valid !== 1'b0) stray = 1;
         @(negedge clk);
      end
      checks++; if (stray) begin errs++; $display("FAIL ign_no_new_frame got=activity exp=idle"); end
      checks++; if (done_cnt != 1) begin errs++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt); end
      checks++; if (rx_q.size() != FRAME) begin errs++; $display("FAIL ign_len got=%0d exp=%0d", rx_q.size(), FRAME); end
      for (int i = 0; i < rx_q.size() && i < 3; i++) begin
         checks++;
         if (rx_q[i] !== exp_byte(24'h0249B4, i)) begin errs++; $display("FAIL ign_key[%0d] got=%h exp=%h", i, rx_q[i], exp_byte(24'h0249B4, i)); end
      end
      if (rx_q.size() == FRAME) begin
         checks++;
         if (rx_q[FRAME-1] !== 8'h60) begin errs++; $display("FAIL ign_last got=%h exp=60", rx_q[FRAME-1]); end
      end
   endtask

   task automatic test_reset_abort();
      logic hit;
      int   cyc;
      hit = 0;
      tx_ready = 1'b1;
      secret_key = 24'h0249B4;
      start = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (xcnt == 13 && tx_valid) begin hit = 1; break; end
      end
      checks++; if (!hit) begin errs++; $display("FAIL abort_reach_byte10 got=timeout exp=reached"); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL abort_tx_valid got=%b exp=0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin errs++; $display("FAIL abort_tx_data got=%h exp=00", tx_data); end
      checks++; if (ram_address !== 5'd0) begin errs++; $display("FAIL abort_ram_address got=%0d exp=0", ram_address); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL abort_busy_done busy=%b done=%b exp=0,0", busy, done); end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      secret_key = 24'h5A0FF0;
      start = 1'b1;
      wait_done(400, cyc);
      checks++; if (cyc != 131) begin errs++; $display("FAIL abort_new_latency got=%0d exp=131", cyc); end
      @(negedge clk);
      checks++; if (done_cnt != 1) begin errs++; $display("FAIL abort_done_count got=%0d exp=1", done_cnt); end
      checks++; if (rx_q.size() != FRAME) begin errs++; $display("FAIL abort_len got=%0d exp=%0d", rx_q.size(), FRAME); end
      for (int i = 0; i < rx_q.size() && i < FRAME; i++) begin
         checks++;
         if (rx_q[i] !== exp_byte(24'h5A0FF0, i)) begin errs++; $display("FAIL abort_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_byte(24'h5A0FF0, i)); end
      end
   endtask

   task automatic test_latency();
      int cyc;
      lat_mode = 1'b1;
      tx_ready = 1'b1;
      secret_key = 24'hA5C33C;
      start = 1'b1;
      wait_done(400, cyc);
      checks++; if (cyc != 131) begin errs++; $display("FAIL lat_done_latency got=%0d exp=131", cyc); end
      @(negedge clk);
      checks++; if (rx_q.size() != FRAME) begin errs++; $display("FAIL lat_len got=%0d exp=%0d", rx_q.size(), FRAME); end
      for (int i = 0; i < rx_q.size() && i < FRAME; i++) begin
         checks++;
         if (rx_q[i] !== exp_byte(24'hA5C33C, i)) begin errs++; $display("FAIL lat_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_byte(24'hA5C33C, i)); end
      end
      lat_mode = 1'b0;
   endtask

   initial begin
      errs = 0;
      checks = 0;
      lat_mode = 1'b0;
      start = 1'b0;
      tx_ready = 1'b0;
      secret_key = 24'h0;
      for (int i = 0; i < 32; i++) mem[i] = 8'h41 + 8'(i);
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_ignore_start();
      test_reset_abort();
      test_latency();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
